// File: rtl/sum_xchg_pkg.sv
// Shared defaults and the output-register state encoding for the partial-sum exchange hub.
package sum_xchg_pkg;

    localparam int unsigned NCORE_MIN = 2;
    localparam int unsigned NCORE_MAX = 8;
    localparam int unsigned NCORE_DEF = 4;
    localparam int unsigned SW_DEF    = 24;
    localparam int unsigned DEPTH_DEF = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sum_xchg_fifo.sv
// Single-clock per-channel sum FIFO; count-based full/empty so all depth entries are usable.
module sum_xchg_fifo
    import sum_xchg_pkg::*;
#(
    parameter int unsigned width = SW_DEF,
    parameter int unsigned depth = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned cw = $clog2(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == cw'(depth));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full & ~flush & ~reset;
        do_pop   = pop & ~empty & ~flush & ~reset;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + aw'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + aw'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + cw'(1);
            2'b01:   cnt_d = cnt_q - cw'(1);
            default: cnt_d = cnt_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/sum_xchg_hub.sv
// N-core partial-sum exchange hub: per-channel FIFOs, lockstep pop, registered total.
// Optional macro SUM_XCHG_SAT_EN clamps the total to sw bits and adds a sticky sat_flag.
module sum_xchg_hub
    import sum_xchg_pkg::*;
#(
    parameter int unsigned ncore = NCORE_DEF,
    parameter int unsigned sw    = SW_DEF,
    parameter int unsigned depth = DEPTH_DEF,
    localparam int unsigned tw   = sw + $clog2(ncore)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ncore-1:0]    core_en,
    input  logic                flush,
    input  logic [ncore-1:0]    in_valid,
    output logic [ncore-1:0]    in_ready,
    input  logic [ncore*sw-1:0] in_sum,
    output logic                total_valid,
    input  logic                total_ready,
    output logic [tw-1:0]       total_sum,
`ifdef SUM_XCHG_SAT_EN
    output logic                sat_flag,
`endif
    output logic [15:0]         row_cnt,
    output logic                ovf_err
);

    logic [sw-1:0]    rdata [ncore];
    logic [ncore-1:0] fifo_full, fifo_empty, push, pop;
    logic [tw-1:0]    sum_all, sum_out;
    logic             fire, sat_hit;

    out_state_e  state_q, state_d;
    logic [tw-1:0] total_sum_q, total_sum_d;
    logic [15:0] row_cnt_q, row_cnt_d;
    logic        ovf_err_q, ovf_err_d;
    logic        sat_flag_q, sat_flag_d;

    assign in_ready = core_en & ~fifo_full & {ncore{~reset & ~flush}};
    assign push     = in_valid & in_ready;
    assign pop      = {ncore{fire}} & core_en;

    for (genvar g = 0; g < ncore; g++) begin : g_ch
        sum_xchg_fifo #(.width(sw), .depth(depth)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .wdata (in_sum[g*sw +: sw]),
            .rdata (rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    always_comb begin
        sum_all = '0;
        for (int unsigned i = 0; i < ncore; i++) begin
            if (core_en[i]) sum_all = sum_all + tw'(rdata[i]);
        end
`ifdef SUM_XCHG_SAT_EN
        sat_hit = |sum_all[tw-1:sw];
        sum_out = sat_hit ? tw'({sw{1'b1}}) : sum_all;
`else
        sat_hit = 1'b0;
        sum_out = sum_all;
`endif
    end

    // Disabled channels count as satisfied, so they never block a fire.
    assign fire = (|core_en) & (&(~core_en | ~fifo_empty))
                & ((state_q == OUT_EMPTY) | total_ready) & ~flush & ~reset;

    always_comb begin
        state_d     = state_q;
        total_sum_d = total_sum_q;
        row_cnt_d   = row_cnt_q;
        ovf_err_d   = ovf_err_q | (|(in_valid & core_en & fifo_full));
        sat_flag_d  = sat_flag_q;
        if (flush) begin
            state_d    = OUT_EMPTY;
            sat_flag_d = 1'b0;
        end else if (fire) begin
            state_d     = OUT_FULL;
            total_sum_d = sum_out;
            row_cnt_d   = row_cnt_q + 16'd1;
            sat_flag_d  = sat_flag_q | sat_hit;
        end else if (total_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OUT_EMPTY;
            total_sum_q <= '0;
            row_cnt_q   <= '0;
            ovf_err_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_sum_q <= total_sum_d;
            row_cnt_q   <= row_cnt_d;
            ovf_err_q   <= ovf_err_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign total_valid = (state_q == OUT_FULL);
    assign total_sum   = total_sum_q;
    assign row_cnt     = row_cnt_q;
    assign ovf_err     = ovf_err_q;
`ifdef SUM_XCHG_SAT_EN
    assign sat_flag    = sat_flag_q;
`else
    logic unused_sat;
    assign unused_sat  = sat_flag_q;
`endif

endmodule

// File: tb/tb_sum_xchg_hub.sv
// Directed self-checking bench for sum_xchg_hub (default 4 channels, 24-bit sums, depth 8).
module tb_sum_xchg_hub;

    localparam int unsigned NC = 4;
    localparam int unsigned SW = 24;
    localparam int unsigned TW = 26;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   core_en;
    logic            flush;
    logic [NC-1:0]   in_valid;
    logic [NC-1:0]   in_ready;
    logic [NC*SW-1:0] in_sum;
    logic            total_valid;
    logic            total_ready;
    logic [TW-1:0]   total_sum;
    logic [15:0]     row_cnt;
    logic            ovf_err;
`ifdef SUM_XCHG_SAT_EN
    logic            sat_flag;
`endif

    int errors = 0;
    int checks = 0;

    sum_xchg_hub #(.ncore(NC), .sw(SW), .depth(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_en     (core_en),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .total_valid (total_valid),
        .total_ready (total_ready),
        .total_sum   (total_sum),
`ifdef SUM_XCHG_SAT_EN
        .sat_flag    (sat_flag),
`endif
        .row_cnt     (row_cnt),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sums(input logic [SW-1:0] s0, s1, s2, s3);
        in_sum = {s3, s2, s1, s0};
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; core_en = '0; in_valid = '0;
        total_ready = 1'b0; in_sum = '0;
        tick(); tick();
        checks++;
        if (total_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", total_valid); end
        checks++;
        if (total_sum !== '0) begin errors++; $display("FAIL reset_sum: got %0h expected 0", total_sum); end
        checks++;
        if (row_cnt !== 16'd0) begin errors++; $display("FAIL reset_rowcnt: got %0d expected 0", row_cnt); end
        checks++;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf_err); end
        core_en = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_inready: got %b expected 0000", in_ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        core_en = 4'b1111; total_ready = 1'b1;
        set_sums(24'd10, 24'd20, 24'd30, 24'd40);
        in_valid = 4'b1111;
        tick();
        in_valid = '0;
        checks++;
        if (total_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got %0b expected 0", total_valid); end
        tick();
        checks++;
        if (total_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", total_valid); end
        checks++;
        if (total_sum !== 26'd100) begin errors++; $display("FAIL basic_sum: got %0d expected 100", total_sum); end
        checks++;
        if (row_cnt !== 16'd1) begin errors++; $display("FAIL basic_rowcnt: got %0d expected 1", row_cnt); end
        tick();
        checks++;
        if (total_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b expected 0", total_valid); end
    endtask

    task automatic test_mask();
        core_en = 4'b0101; total_ready = 1'b1;
        set_sums(24'd5, 24'd99, 24'd7, 24'd0);
        in_valid = 4'b0111;
        #1;
        checks++;
        if (in_ready !== 4'b0101) begin errors++; $display("FAIL mask_inready: got %b expected 0101", in_ready); end
        tick();
        in_valid = '0;
        tick();
        checks++;
        if (total_sum !== 26'd12) begin errors++; $display("FAIL mask_sum: got %0d expected 12", total_sum); end
        checks++;
        if (row_cnt !== 16'd2) begin errors++; $display("FAIL mask_rowcnt: got %0d expected 2", row_cnt); end
        checks++;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL mask_ovf: got %0b expected 0", ovf_err); end
        tick();
    endtask

    // Channel i entry k carries 16k+i, so total k is 64k+6.
    task automatic test_overflow_stream();
        core_en = 4'b1111; total_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_sums(SW'(16*k), SW'(16*k + 1), SW'(16*k + 2), SW'(16*k + 3));
            in_valid = 4'b1111;
            tick();
        end
        in_valid = '0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL ovf_full_inready: got %b expected 0000", in_ready); end
        checks++;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %0b expected 0", ovf_err); end
        set_sums(24'hABCDEF, 24'd0, 24'd0, 24'd0);
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", ovf_err); end
        total_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (total_valid !== 1'b1 || total_sum !== TW'(64*k + 6)) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%0b sum=%0d expected valid=1 sum=%0d", k, total_valid, total_sum, 64*k + 6);
            end
            tick();
        end
        checks++;
        if (total_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %0b expected 0", total_valid); end
        checks++;
        if (row_cnt !== 16'd11) begin errors++; $display("FAIL stream_rowcnt: got %0d expected 11", row_cnt); end
    endtask

    task automatic test_max_sum();
        core_en = 4'b1111; total_ready = 1'b1;
`ifdef SUM_XCHG_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_pre: got %0b expected 0", sat_flag); end
`endif
        set_sums(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        in_valid = 4'b1111;
        tick();
        in_valid = '0;
        tick();
`ifdef SUM_XCHG_SAT_EN
        checks++;
        if (total_sum !== 26'h0FFFFFF) begin errors++; $display("FAIL max_sum: got %0h expected ffffff", total_sum); end
        checks++;
        if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b expected 1", sat_flag); end
`else
        checks++;
        if (total_sum !== 26'h3FFFFFC) begin errors++; $display("FAIL max_sum: got %0h expected 3fffffc", total_sum); end
`endif
        tick();
    endtask

    task automatic test_flush();
        core_en = 4'b1111; total_ready = 1'b0;
        set_sums(24'd1, 24'd2, 24'd3, 24'd4);
        in_valid = 4'b1111;
        tick();
        set_sums(24'd5, 24'd6, 24'd7, 24'd8);
        tick();
        in_valid = '0;
        checks++;
        if (total_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %0b expected 1", total_valid); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (total_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b expected 0", total_valid); end
        checks++;
        if (row_cnt !== 16'd13) begin errors++; $display("FAIL flush_rowcnt: got %0d expected 13", row_cnt); end
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL flush_ovf: got %0b expected 1", ovf_err); end
`ifdef SUM_XCHG_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL flush_sat: got %0b expected 0", sat_flag); end
`endif
        total_ready = 1'b1;
        tick(); tick();
        checks++;
        if (total_valid !== 1'b0 || row_cnt !== 16'd13) begin
            errors++;
            $display("FAIL flush_empty: got valid=%0b rowcnt=%0d expected valid=0 rowcnt=13", total_valid, row_cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int gaps;
        core_en = 4'b1111; total_ready = 1'b1;
        set_sums(24'd1, 24'd1, 24'd1, 24'd1);
        in_valid = 4'b1111;
        gaps = 0;
        for (int i = 0; i < 65523; i++) begin
            tick();
            if (i > 0 && total_valid !== 1'b1) gaps++;
        end
        in_valid = '0;
        tick();
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps: got %0d expected 0", gaps); end
        checks++;
        if (row_cnt !== 16'd0) begin errors++; $display("FAIL wrap_rowcnt: got %0d expected 0", row_cnt); end
        checks++;
        if (total_sum !== 26'd4) begin errors++; $display("FAIL wrap_sum: got %0d expected 4", total_sum); end
        in_valid = 4'b1111;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (total_valid !== 1'b0 || total_sum !== '0 || row_cnt !== 16'd0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got valid=%0b sum=%0d rowcnt=%0d ovf=%0b expected all 0", total_valid, total_sum, row_cnt, ovf_err);
        end
        reset = 1'b0;
        in_valid = '0;
        tick(); tick();
        checks++;
        if (total_valid !== 1'b0 || row_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_discard: got valid=%0b rowcnt=%0d expected 0 0", total_valid, row_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_overflow_stream();
        test_max_sum();
        test_flush();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
